alu_seq_slice: RTL
==================

Name: alu_seq_slice

Overview:
- Parametrised multi-cycle Z80-style ALU that processes a WIDTH-bit operation SLICE_W bits per clock, low slice first.
- Latches the inter-slice carry in a register between passes, the way the Z80 runs 8-bit arithmetic as two 4-bit nibble passes.
- Produces a WIDTH-bit result plus S, Z, H, P/V, N, C flags.
- Sits between the register file operand latches and the flag register.

Parameters:
- WIDTH, 8, operand/result width; must be a multiple of SLICE_W.
- SLICE_W, 4, bits processed per pass; NPASS = WIDTH/SLICE_W (at least 1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  request; sampled only when busy=0.
- op  in  3  operation: ADD=0, ADC=1, SUB=2, SBC=3, AND=4, XOR=5, OR=6, CP=7.
- a  in  WIDTH  operand 1 (accumulator).
- b  in  WIDTH  operand 2.
- cy_in  in  1  carry flag in; used by ADC/SBC only.
- busy  out  1  high while passes are executing.
- done  out  1  one-cycle completion pulse.
- result  out  WIDTH  result; held between operations.
- flags  out  6  {S,Z,H,PV,N,C}, bit 5 down to bit 0; held between operations.

Behaviour:
- Reset: rst_n=0 at a rising edge clears state to IDLE. busy=0, done=0, result=0, flags=0, pass counter=0, carry latch=0.
- Reset mid-operation aborts the operation. No done is produced.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, executes passes 0..NPASS-1.
  - FIN: busy=0, done=1 for exactly one cycle.
- Transitions:
  - IDLE/FIN with start=1 -> RUN. a, b, op and the effective carry are latched at that edge.
  - IDLE/FIN with start=0 -> IDLE.
  - RUN at pass NPASS-1 -> FIN.
  - FIN with start=1 -> RUN. Back-to-back operations are therefore allowed. done still pulses this cycle.
- start while busy=1 is ignored. Latched operands are unaffected.
- Latency: start sampled at edge T gives busy=1 for cycles T..T+NPASS-1. done=1 in the cycle after edge T+NPASS. result and flags are updated at that same edge.
- Pass k operates on bits [k*SLICE_W +: SLICE_W]. Slice carry out goes to the carry latch, and the latch feeds pass k+1.
- Initial carry:
  - ADD, AND, XOR, OR: 0.
  - ADC: cy_in.
  - SUB, CP: 1.
  - SBC: ~cy_in.
- SUB/SBC/CP use the inverted b.
- C flag:
  - ADD/ADC: final carry.
  - SUB/SBC/CP: ~final carry (borrow).
  - Logic ops: 0.
- H flag:
  - Arithmetic: carry (ADD/ADC) or ~carry (SUB/SBC/CP) out of bit 3, captured during the pass containing bit 3. If WIDTH<4, H=0.
  - AND: 1.
  - XOR/OR: 0.
- PV flag:
  - Arithmetic: two's-complement overflow, i.e. carry into MSB XOR carry out of MSB.
  - Logic: even parity of the result (1 = even number of ones).
- N flag: 1 for SUB/SBC/CP, else 0.
- S flag: result MSB.
- Z flag: 1 when the full WIDTH-bit computed value is 0. Evaluated on the complete value, not per slice.
- CP: flags are computed exactly as SUB, but the result output is not updated and keeps its previous value.
- Wrap-around: arithmetic is modulo 2^WIDTH; the carry/borrow leaving the MSB is visible only in C.
- NPASS=1 is legal: RUN lasts one cycle.

Decomposition:
- Package alu_seq_pkg holds:
  - op encodings (OP_ADD..OP_CP);
  - flag bit indices (FLAG_S=5, FLAG_Z=4, FLAG_H=3, FLAG_PV=2, FLAG_N=1, FLAG_C=0);
  - state encoding (ST_IDLE, ST_RUN, ST_FIN).
- One combinational sub-module, alu_slice_w, parameter SLICE_W:
  - inputs: op1, op2, invert, logic-select, cy_in;
  - outputs: result slice, cy_out, carry into the slice MSB (for overflow), and the carry out of slice bit 3 when present.
- The top module owns the FSM, pass counter, carry latch, operand latches and flag assembly.

Test Plan:
1. WIDTH=8, SLICE_W=4: ADD a=0x0F, b=0x01 -> busy for 2 cycles, done pulse on the 3rd cycle after start. result=0x10, flags S0 Z0 H1 PV0 N0 C0.
2. ADD a=0x7F, b=0x01 -> result=0x80, S1 Z0 H1 PV1 N0 C0. Then ADC a=0xFF, b=0x00, cy_in=1 -> result=0x00, Z1 H1 C1 PV0.
3. SUB a=0x00, b=0x01 -> result=0xFF, S1 H1 N1 C1 PV0. Immediately after, CP a=0x42, b=0x42 -> result stays 0xFF, Z1 N1 C0 H0.
4. XOR a=0x5A, b=0x5A -> result=0x00, Z1 PV1 C0 H0. AND a=0xF0, b=0x3C -> result=0x30, H1 PV1 C0.
5. Assert start again in the FIN cycle of an ADD -> the second op starts with no idle gap and done pulses twice. start held high during RUN -> ignored, latched operands unchanged.
6. rst_n=0 for one edge during pass 0 -> next cycle busy=0, done=0, result=0x00, flags=0, and no done pulse follows. Repeat test 1 with WIDTH=16, SLICE_W=4 -> 4-cycle busy, 0x000F+0x0001=0x0010, H1.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// ============================================================================
// Module   : alu_seq_pkg
// Brief    : Shared op codes, flag bit positions and FSM states for the
//            slice-sequential ALU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_ADC = 3'd1,
        OP_SUB = 3'd2,
        OP_SBC = 3'd3,
        OP_AND = 3'd4,
        OP_XOR = 3'd5,
        OP_OR  = 3'd6,
        OP_CP  = 3'd7
    } op_e;

    localparam int FLAG_S  = 5;
    localparam int FLAG_Z  = 4;
    localparam int FLAG_H  = 3;
    localparam int FLAG_PV = 2;
    localparam int FLAG_N  = 1;
    localparam int FLAG_C  = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        LSEL_ARITH = 2'd0,
        LSEL_AND   = 2'd1,
        LSEL_XOR   = 2'd2,
        LSEL_OR    = 2'd3
    } lsel_e;

    function automatic logic is_sub_op(input op_e op);
        return (op == OP_SUB) || (op == OP_SBC) || (op == OP_CP);
    endfunction

    // Subtraction runs as a + ~b + 1, so the borrow-in appears inverted.
    function automatic logic init_carry(input op_e op, input logic cy);
        case (op)
            OP_ADC:        return cy;
            OP_SUB, OP_CP: return 1'b1;
            OP_SBC:        return ~cy;
            default:       return 1'b0;
        endcase
    endfunction

    function automatic lsel_e lsel_of(input op_e op);
        case (op)
            OP_AND:  return LSEL_AND;
            OP_XOR:  return LSEL_XOR;
            OP_OR:   return LSEL_OR;
            default: return LSEL_ARITH;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_slice_w.sv
// ============================================================================
// Module   : alu_slice_w
// Brief    : Combinational SLICE_W-bit ALU slice with ripple carry taps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_slice_w
    import alu_seq_pkg::*;
#(
    parameter int SLICE_W = 4
) (
    input  logic [SLICE_W-1:0] op1,
    input  logic [SLICE_W-1:0] op2,
    input  logic               invert,
    input  lsel_e              logic_sel,
    input  logic               cy_in,
    output logic [SLICE_W-1:0] res,
    output logic               cy_out,
    output logic               cy_msb,
    output logic               cy_h
);

    // Local position of global bit 3 within whichever slice holds it.
    localparam int c_h_loc = 3 % SLICE_W;

    logic [SLICE_W-1:0] w_b;
    logic [SLICE_W-1:0] w_sum;
    logic [SLICE_W:0]   w_c;

    always_comb begin
        w_b    = invert ? ~op2 : op2;
        w_c    = '0;
        w_sum  = '0;
        w_c[0] = cy_in;
        for (int i = 0; i < SLICE_W; i++) begin
            w_sum[i]  = op1[i] ^ w_b[i] ^ w_c[i];
            w_c[i+1]  = (op1[i] & w_b[i]) | (op1[i] & w_c[i]) | (w_b[i] & w_c[i]);
        end
    end

    always_comb begin
        res = w_sum;
        case (logic_sel)
            LSEL_AND: res = op1 & op2;
            LSEL_XOR: res = op1 ^ op2;
            LSEL_OR:  res = op1 | op2;
            default:  res = w_sum;
        endcase
    end

    assign cy_out = w_c[SLICE_W];
    assign cy_msb = w_c[SLICE_W-1];
    assign cy_h   = w_c[c_h_loc+1];

endmodule

`default_nettype wire

// File: rtl/alu_seq_slice.sv
// ============================================================================
// Module   : alu_seq_slice
// Brief    : Multi-cycle Z80-style ALU, WIDTH bits processed SLICE_W per clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq_slice
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SLICE_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cy_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [5:0]       flags
);

    localparam int             c_npass     = WIDTH / SLICE_W;
    localparam int             c_pw        = (c_npass > 1) ? $clog2(c_npass) : 1;
    localparam logic [c_pw-1:0] c_last_pass = c_pw'(c_npass - 1);
    localparam logic           c_has_h     = (WIDTH >= 4);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [c_pw-1:0]    r_pass;
    logic               r_cy;
    logic               r_h;
    op_e                r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_result;
    logic [5:0]         r_flags;

    logic               w_accept;
    logic               w_inv;
    lsel_e              w_lsel;
    logic [SLICE_W-1:0] w_op1;
    logic [SLICE_W-1:0] w_op2;
    logic [SLICE_W-1:0] w_res;
    logic               w_cy_out;
    logic               w_cy_msb;
    logic               w_cy_h;
    logic               w_h_here;
    logic               w_h_cur;
    logic [WIDTH-1:0]   w_full;
    logic [5:0]         w_flags;

    assign w_accept = start && (r_state != ST_RUN);
    assign w_inv    = is_sub_op(r_op);
    assign w_lsel   = lsel_of(r_op);
    assign w_op1    = r_a[r_pass*SLICE_W +: SLICE_W];
    assign w_op2    = r_b[r_pass*SLICE_W +: SLICE_W];

    alu_slice_w #(
        .SLICE_W (SLICE_W)
    ) u_slice (
        .op1       (w_op1),
        .op2       (w_op2),
        .invert    (w_inv),
        .logic_sel (w_lsel),
        .cy_in     (r_cy),
        .res       (w_res),
        .cy_out    (w_cy_out),
        .cy_msb    (w_cy_msb),
        .cy_h      (w_cy_h)
    );

    generate
        if (WIDTH >= 4) begin : g_half
            localparam logic [c_pw-1:0] c_h_pass = c_pw'(3 / SLICE_W);
            assign w_h_here = (r_pass == c_h_pass);
        end else begin : g_no_half
            assign w_h_here = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_FIN: w_state_nxt = start ? ST_RUN : ST_IDLE;
            ST_RUN:          if (r_pass == c_last_pass) w_state_nxt = ST_FIN;
            default:         w_state_nxt = ST_IDLE;
        endcase
    end

    // Final value: earlier slices from the accumulator, current slice live.
    always_comb begin
        w_full = r_acc;
        w_full[r_pass*SLICE_W +: SLICE_W] = w_res;
        w_h_cur = w_h_here ? w_cy_h : r_h;

        w_flags         = '0;
        w_flags[FLAG_S] = w_full[WIDTH-1];
        w_flags[FLAG_Z] = (w_full == '0);
        w_flags[FLAG_N] = w_inv;
        if (w_lsel == LSEL_ARITH) begin
            w_flags[FLAG_C]  = w_cy_out ^ w_inv;
            w_flags[FLAG_H]  = c_has_h & (w_h_cur ^ w_inv);
            w_flags[FLAG_PV] = w_cy_msb ^ w_cy_out;
        end else begin
            w_flags[FLAG_H]  = (w_lsel == LSEL_AND);
            w_flags[FLAG_PV] = ~^w_full;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pass   <= '0;
            r_cy     <= 1'b0;
            r_h      <= 1'b0;
            r_op     <= OP_ADD;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_flags  <= '0;
        end else if (w_accept) begin
            r_pass <= '0;
            r_cy   <= init_carry(op_e'(op), cy_in);
            r_h    <= 1'b0;
            r_op   <= op_e'(op);
            r_a    <= a;
            r_b    <= b;
        end else if (r_state == ST_RUN) begin
            r_cy <= w_cy_out;
            r_acc[r_pass*SLICE_W +: SLICE_W] <= w_res;
            if (w_h_here) r_h <= w_cy_h;
            if (r_pass == c_last_pass) begin
                r_pass  <= '0;
                r_flags <= w_flags;
                if (r_op != OP_CP) r_result <= w_full;
            end else begin
                r_pass <= r_pass + 1'b1;
            end
        end
    end

    assign busy   = (r_state == ST_RUN);
    assign done   = (r_state == ST_FIN);
    assign result = r_result;
    assign flags  = r_flags;

endmodule

`default_nettype wire
